module_bcd_conv: RTL and testbench
==================================

// Module: module_bcd_conv
// PURPOSE
//  Parametrised sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Sits between the arithmetic stage (sumador) and the seven-segment driver.
//  Converts any DATA_W-bit result to DIGITS BCD digits.
//  Valid/ready handshakes on both sides; saturating overflow flag.
// PARAMETERS
//  DATA_W  16  binary input width; legal range >= 4
//  DIGITS   4  number of BCD output digits; legal range >= 1
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           bin_in is valid
//  in_ready   out  1           converter can accept bin_in
//  bin_in     in   DATA_W      binary value (unsigned; two's complement with SIGNED_EN)
//  out_valid  out  1           bcd_out/overflow/neg are valid
//  out_ready  in   1           consumer takes the result
//  bcd_out    out  4*DIGITS    BCD result; digit 0 (units) in bits [3:0]
//  overflow   out  1           value > 10^DIGITS-1; bcd_out saturated to all 9s
//  neg        out  1           input was negative (SIGNED_EN only, else tied 0)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, out_valid=0, bcd_out=0, overflow=0, neg=0.
//   In-flight conversion is discarded. rst has priority over every other event.
//  FSM: IDLE -> SHIFT -> DONE -> (IDLE | SHIFT).
//  IDLE:
//   in_ready=1.
//   in_valid=1 at an edge: load shift reg with bin_in (magnitude under SIGNED_EN).
//   Same edge: clear BCD reg and ovf, bit_cnt=DATA_W, go SHIFT.
//  SHIFT: in_ready=0. Each edge performs one step:
//   1. every digit >=5 gets +3;
//   2. shift {bcd,shreg} left 1;
//   3. the bit leaving the top digit ORs into sticky ovf;
//   4. bit_cnt-1.
//   The edge that performs the DATA_W-th step also moves to DONE with out_valid=1.
//  Latency: out_valid is high after exactly DATA_W edges following the accepting edge.
//  DONE:
//   out_valid=1; bcd_out/overflow/neg held stable until handshake.
//   If ovf: bcd_out = all digits 4'h9, overflow=1.
//   out_ready=1 at an edge: result consumed, out_valid drops.
//   That edge also goes to SHIFT if in_valid=1 (new accept), else to IDLE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational out_ready->in_ready path is allowed.
//  Max throughput: one result per DATA_W+1 cycles with both sides always ready.
//  in_valid while in SHIFT, or in DONE with out_ready=0: ignored, not queued.
//  bin_in=0: bcd_out=0, still DATA_W cycles.
//  Exactly 10^DIGITS-1: no overflow. Exactly 10^DIGITS: overflow.
// CONFIGURATION
//  SIGNED_EN defined:
//   bin_in is two's complement.
//   On accept, neg=bin_in[DATA_W-1] and the shift reg loads |bin_in| (DATA_W-bit unsigned).
//   -2^(DATA_W-1) converts correctly.
//   neg is registered with the result and valid with out_valid.
//  SIGNED_EN undefined: bin_in is unsigned, neg is constant 0, no negate logic.
// TESTING (DATA_W=16, DIGITS=4 unless stated)
//  1. bin_in=1234, out_ready=1 -> bcd_out=16'h1234, overflow=0; out_valid exactly 16 edges after accept.
//  2. 9999 -> 16'h9999, ovf=0. 10000 -> 16'h9999, ovf=1. 65535 -> 16'h9999, ovf=1. 0 -> 16'h0000.
//  3. Stall: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     An in_valid pulse is ignored; release out_ready -> single result.
//  4. Back-to-back: in_valid=1 with 0 then 42, out_ready=1 -> 42 accepted on the DONE edge.
//     Results 16'h0000 then 16'h0042, 17 cycles apart.
//  5. rst at 7th SHIFT cycle of 500 -> next edge out_valid=0, in_ready=1, outputs 0.
//     Then converting 7 gives 16'h0007.
//  6. SIGNED_EN: 16'hFB2E (-1234) -> neg=1, 16'h1234.
//     16'h8000 -> neg=1, ovf=1, 16'h9999.
//     DIGITS=5, 16'h8000 -> 20'h32768, ovf=0.

Source files
------------

// File: rtl/module_bcd_conv_if.sv
// Handshake bundle for the binary-to-BCD converter.
//   master : producer/consumer side (drives bin_in/in_valid and out_ready)
//   slave  : converter side (drives in_ready and the result group)
// Signals:
//   in_valid/in_ready/bin_in          input handshake and binary operand
//   out_valid/out_ready               output handshake
//   bcd_out/overflow/neg              result, saturation flag, sign flag
interface module_bcd_conv_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic                  neg;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, overflow, neg
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, overflow, neg
    );
endinterface

// File: rtl/module_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous reset, active-high
//   bus  module_bcd_conv_if.slave: valid/ready in (bin_in), valid/ready out
//        (bcd_out, overflow, neg)
// Parameters: DATA_W (>= 4) input width, DIGITS (>= 1) BCD digits out.
// Optional macro SIGNED_EN: bin_in is two's complement, converter works on
// |bin_in| and reports the sign on neg. Without it neg is tied low.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | one add-3/shift step per clock, bit_cnt counts down to 1
// DONE  | result valid, held until out_ready; may accept the next operand
module module_bcd_conv #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    module_bcd_conv_if.slave    bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;

    logic [DATA_W-1:0]   load_val;
    logic                load_neg;
    logic [BCD_W-1:0]    bcd_adj;
    logic                accept;

`ifdef SIGNED_EN
    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    assign load_neg = bus.bin_in[DATA_W-1];
    assign load_val = load_neg ? (~bus.bin_in + 1'b1) : bus.bin_in;
`else
    assign load_neg = 1'b0;
    assign load_val = bus.bin_in;
`endif

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.overflow  = ovf_q;
    assign bus.bcd_out   = ovf_q ? {DIGITS{4'h9}} : bcd_q;
`ifdef SIGNED_EN
    assign bus.neg       = neg_q;
`else
    assign bus.neg       = 1'b0;
`endif

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;

        case (state_q)
            SHIFT: begin
                // The bit pushed out of the top digit means the value no
                // longer fits; keep it sticky so the result saturates.
                ovf_d   = ovf_q | bcd_adj[BCD_W-1];
                bcd_d   = {bcd_adj[BCD_W-2:0], shreg_q[DATA_W-1]};
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = SHIFT;
            shreg_d = load_val;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CNT_W'(DATA_W);
            neg_d   = load_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

`ifndef SIGNED_EN
    logic unused_neg;
    assign unused_neg = neg_q;
`endif
endmodule

// File: tb/tb_module_bcd_conv.sv
module tb_module_bcd_conv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n;

    always #5 clk = ~clk;

    module_bcd_conv_if #(.DATA_W(16), .DIGITS(4)) bus ();

    module_bcd_conv #(.DATA_W(16), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic convert(input string tag, input logic [15:0] val,
                           input logic [15:0] exp_bcd, input logic exp_ovf,
                           input logic exp_neg);
        int lat;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.bin_in   = val;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp_bcd));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        chk({tag, "_neg"}, 32'(bus.neg), 32'(exp_neg));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_consumed"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_bcd",       32'(bus.bcd_out),   32'd0);
        chk("rst_ovf",       32'(bus.overflow),  32'd0);
        chk("rst_neg",       32'(bus.neg),       32'd0);

        convert("c1234",  16'd1234,  16'h1234, 1'b0, 1'b0);
        convert("c9999",  16'd9999,  16'h9999, 1'b0, 1'b0);
        convert("c10000", 16'd10000, 16'h9999, 1'b1, 1'b0);
`ifdef SIGNED_EN
        convert("cm1",    16'hFFFF,  16'h0001, 1'b0, 1'b1);
        convert("cm1234", 16'hFB2E,  16'h1234, 1'b0, 1'b1);
        convert("cmin",   16'h8000,  16'h9999, 1'b1, 1'b1);
`else
        convert("c65535", 16'd65535, 16'h9999, 1'b1, 1'b0);
`endif
        convert("c0",     16'd0,     16'h0000, 1'b0, 1'b0);

        // stall in DONE with an ignored in_valid pulse
        bus.bin_in   = 16'd321;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("stall_latency", 32'(n), 32'd16);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.bin_in   = 16'd777;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            chk("stall_valid",    32'(bus.out_valid), 32'd1);
            chk("stall_bcd",      32'(bus.bcd_out),   32'h0321);
            chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.out_ready = 1'b0;
        chk("stall_drop",  32'(bus.out_valid), 32'd0);
        chk("stall_idle",  32'(bus.in_ready),  32'd1);
        tick();
        tick();
        chk("stall_single", 32'(bus.out_valid), 32'd0);

        // back-to-back
        bus.out_ready = 1'b1;
        bus.bin_in    = 16'd0;
        bus.in_valid  = 1'b1;
        tick();
        bus.bin_in    = 16'd42;
        wait_valid(n);
        chk("b2b_first_lat", 32'(n), 32'd16);
        chk("b2b_first_bcd", 32'(bus.bcd_out), 32'h0000);
        chk("b2b_in_ready",  32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_reaccept", 32'(bus.out_valid), 32'd0);
        wait_valid(n);
        chk("b2b_gap",        32'(n + 1), 32'd17);
        chk("b2b_second_bcd", 32'(bus.bcd_out), 32'h0042);
        tick();
        bus.out_ready = 1'b0;
        chk("b2b_drop", 32'(bus.out_valid), 32'd0);

        // reset mid-conversion
        bus.bin_in   = 16'd500;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mrst_bcd",       32'(bus.bcd_out),   32'd0);
        chk("mrst_ovf",       32'(bus.overflow),  32'd0);
        convert("c7", 16'd7, 16'h0007, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
